// File: rtl/uart_txd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_txd_arbiter_pkg
// Description : Shared definitions for the UART TX frame arbiter: FSM state
//               encoding, owner_o encodings, drop counter width and the
//               bit-period derivation helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_txd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_DBG  = 2'd1,
        ST_OWN_UART = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_DBG  = 2'b01;
    localparam logic [1:0] OWNER_UART = 2'b10;

    localparam int DROP_W = 8;

    // Clock cycles per serial bit; the clock is an integer multiple of the baud.
    function automatic int calc_bit_cyc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // owner_o encoding of an FSM state.
    function automatic logic [1:0] owner_of(input arb_state_t st);
        logic [1:0] enc;
        case (st)
            ST_OWN_DBG:  enc = OWNER_DBG;
            ST_OWN_UART: enc = OWNER_UART;
            default:     enc = OWNER_NONE;
        endcase
        return enc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_txd_arbiter_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_tracker
// Description : Follows one idle-high serial line and reports where frames
//               begin. A start pulse is issued on a 1->0 transition while no
//               frame is in progress; the tracker then stays busy for one
//               frame window so data-bit falling edges are not mistaken for
//               start bits. A line still low at the end of the window keeps
//               the tracker busy until it returns high.
// Ports       : clk_w     - system clock
//               rst_sys_w - asynchronous active-high reset
//               rxd_i     - registered serial line (idle high)
//               start_o   - combinational start-of-frame pulse
//               busy_o    - a frame window is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_tracker #(
    parameter int BIT_CYC    = 25,
    parameter int FRAME_BITS = 10
) (
    input  logic clk_w,
    input  logic rst_sys_w,
    input  logic rxd_i,
    output logic start_o,
    output logic busy_o
);

    localparam int FRAME_CYC = BIT_CYC * FRAME_BITS;
    localparam int CNT_W     = $clog2(FRAME_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);

    logic             prev_q;
    logic             busy_q;
    logic             busy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The start cycle itself is cycle 0 of the window, so the counter is
    // loaded with 1: the window then ends on the last stop-bit cycle and a
    // back-to-back start bit on the following cycle is still recognised.
    assign start_o = prev_q & ~rxd_i & ~busy_q;
    assign busy_o  = busy_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start_o) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(1);
        end else if (busy_q) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else if (rxd_i) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_w or posedge rst_sys_w) begin
        if (rst_sys_w) begin
            prev_q <= 1'b1;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= rxd_i;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_txd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_txd_arbiter
// Description : Frame-level arbiter merging the debug-bridge and console TX
//               streams onto one pin. The first source to begin a frame owns
//               the pin until its line has been idle for IDLE_BITS bit-times;
//               start bits from the other source during ownership are dropped
//               and counted. Pin-to-pin latency is exactly two clocks.
// Ports       : clk_w        - system clock
//               rst_sys_w    - asynchronous active-high reset
//               dbg_txd_i    - debug-bridge serial TX (idle high)
//               uart_txd_i   - console UART serial TX (idle high)
//               txd_o        - merged line to the pin (IOB flop)
//               owner_o      - 00 none, 01 dbg, 10 uart
//               drop_count_o - saturating count of dropped frames
// Revision    : 1.0 - initial release
// ============================================================================
module uart_txd_arbiter
    import uart_txd_arbiter_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 1000000,
    parameter int IDLE_BITS  = 12,
    parameter int FRAME_BITS = 10
) (
    input  logic              clk_w,
    input  logic              rst_sys_w,
    input  logic              dbg_txd_i,
    input  logic              uart_txd_i,
    output logic              txd_o,
    output logic [1:0]        owner_o,
    output logic [DROP_W-1:0] drop_count_o
);

    localparam int BIT_CYC  = calc_bit_cyc(CLK_HZ, BAUD);
    localparam int IDLE_CYC = IDLE_BITS * BIT_CYC;
    localparam int IDLE_W   = $clog2(IDLE_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
    localparam logic [DROP_W-1:0] DROP_MAX  = '1;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic dbg_q;
    logic uart_q;

    always_ff @(posedge clk_w or posedge rst_sys_w) begin
        if (rst_sys_w) begin
            dbg_q  <= 1'b1;
            uart_q <= 1'b1;
        end else begin
            dbg_q  <= dbg_txd_i;
            uart_q <= uart_txd_i;
        end
    end

    // ------------------------------------------------------------------
    // Frame trackers
    // ------------------------------------------------------------------
    logic dbg_start;
    logic dbg_busy;
    logic uart_start;
    logic uart_busy;

    uart_frame_tracker #(
        .BIT_CYC    (BIT_CYC),
        .FRAME_BITS (FRAME_BITS)
    ) u_dbg_trk (
        .clk_w     (clk_w),
        .rst_sys_w (rst_sys_w),
        .rxd_i     (dbg_q),
        .start_o   (dbg_start),
        .busy_o    (dbg_busy)
    );

    uart_frame_tracker #(
        .BIT_CYC    (BIT_CYC),
        .FRAME_BITS (FRAME_BITS)
    ) u_uart_trk (
        .clk_w     (clk_w),
        .rst_sys_w (rst_sys_w),
        .rxd_i     (uart_q),
        .start_o   (uart_start),
        .busy_o    (uart_busy)
    );

    // A source is only eligible at the start of a fresh frame; a source
    // that is mid-frame when the grant is released must wait for its next
    // start bit so a partial frame never reaches the pin.
    logic dbg_elig;
    logic uart_elig;

    assign dbg_elig  = dbg_start  & ~dbg_busy;
    assign uart_elig = uart_start & ~uart_busy;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic              own_line;
    logic              drop_inc;

    assign own_line = (state_q == ST_OWN_DBG) ? dbg_q : uart_q;

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        drop_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_d = '0;
                if (dbg_elig) begin
                    state_d  = ST_OWN_DBG;
                    // dbg wins a tie; the console frame is lost.
                    drop_inc = uart_elig;
                end else if (uart_elig) begin
                    state_d = ST_OWN_UART;
                end
            end
            ST_OWN_DBG, ST_OWN_UART: begin
                drop_inc = (state_q == ST_OWN_DBG) ? uart_elig : dbg_elig;
                // Idle time is measured on the owner line only; any low
                // cycle (start or data bit) restarts the measurement.
                if (!own_line) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_IDLE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idle_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Drop counter and output register
    // ------------------------------------------------------------------
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;
    logic              txd_d;
    logic [1:0]        owner_q;

    (* IOB = "TRUE" *) logic txd_q;

    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Muxing on the next state lets the granting start bit through with
    // no extra delay, keeping the pin-to-pin latency at two clocks.
    always_comb begin
        case (state_d)
            ST_OWN_DBG:  txd_d = dbg_q;
            ST_OWN_UART: txd_d = uart_q;
            default:     txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_w or posedge rst_sys_w) begin
        if (rst_sys_w) begin
            state_q <= ST_IDLE;
            idle_q  <= '0;
            drop_q  <= '0;
            txd_q   <= 1'b1;
            owner_q <= OWNER_NONE;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            drop_q  <= drop_d;
            txd_q   <= txd_d;
            owner_q <= owner_of(state_d);
        end
    end

    assign txd_o        = txd_q;
    assign owner_o      = owner_q;
    assign drop_count_o = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_txd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_txd_arbiter
// Description : Self-checking bench for uart_txd_arbiter. A frame-level
//               reference model pushes the expected output of every clock
//               into a queue; a monitor on the falling edge pops and compares.
//               Directed checks cover the scenario end points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_txd_arbiter;

    localparam int BIT_CYC    = 25;
    localparam int FRAME_BITS = 10;
    localparam int IDLE_BITS  = 12;
    localparam int FRAME_CYC  = BIT_CYC * FRAME_BITS;
    localparam int IDLE_CYC   = IDLE_BITS * BIT_CYC;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       dbg_pin  = 1'b1;
    logic       uart_pin = 1'b1;
    logic       txd;
    logic [1:0] owner;
    logic [7:0] drops;

    uart_txd_arbiter #(
        .CLK_HZ     (25000000),
        .BAUD       (1000000),
        .IDLE_BITS  (IDLE_BITS),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .clk_w        (clk),
        .rst_sys_w    (rst),
        .dbg_txd_i    (dbg_pin),
        .uart_txd_i   (uart_pin),
        .txd_o        (txd),
        .owner_o      (owner),
        .drop_count_o (drops)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       txd;
        logic [1:0] owner;
        logic [7:0] drops;
    } exp_t;

    exp_t exp_q[$];

    // ------------------------------------------------------------------
    // Reference model (index 0 = dbg, 1 = uart; owner 0 none, 1 dbg, 2 uart)
    // m_line = line value during the cycle just ended, m_prev = the one before.
    // A frame occupies FRAME_CYC cycles from its start bit and ends at the
    // first high cycle at or after its last window cycle.
    // ------------------------------------------------------------------
    logic m_line[2];
    logic m_prev[2];
    bit   m_infr[2];
    int   m_fstart[2];
    bit   m_st[2];
    int   m_owner;
    int   m_run;
    int   m_drops;
    int   m_t;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_line[s] = 1'b1; m_prev[s] = 1'b1; m_infr[s] = 0; m_fstart[s] = 0;
        end
        m_owner = 0; m_run = 0; m_drops = 0; m_t = 0;
    endtask

    task automatic model_step();
        exp_t e;
        int   o;
        for (int s = 0; s < 2; s++)
            m_st[s] = m_prev[s] && !m_line[s] && !m_infr[s];
        if (m_owner == 0) begin
            if (m_st[0]) begin
                m_owner = 1; m_run = 0;
                if (m_st[1]) m_drops = m_drops + 1;
            end else if (m_st[1]) begin
                m_owner = 2; m_run = 0;
            end
        end else begin
            o = m_owner - 1;
            if (m_st[1 - o]) m_drops = m_drops + 1;
            m_run = m_line[o] ? m_run + 1 : 0;
            if (m_run >= IDLE_CYC) m_owner = 0;
        end
        if (m_drops > 255) m_drops = 255;
        for (int s = 0; s < 2; s++) begin
            if (m_st[s]) begin
                m_infr[s] = 1; m_fstart[s] = m_t;
            end else if (m_infr[s] && (m_t - m_fstart[s] >= FRAME_CYC - 1) && m_line[s]) begin
                m_infr[s] = 0;
            end
        end
        e.owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        e.txd   = (m_owner == 1) ? m_line[0] : (m_owner == 2) ? m_line[1] : 1'b1;
        e.drops = 8'(m_drops);
        exp_q.push_back(e);
        m_prev[0] = m_line[0];
        m_prev[1] = m_line[1];
        m_line[0] = dbg_pin;
        m_line[1] = uart_pin;
        m_t = m_t + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int mon_cyc = 0;

    task automatic monitor_step();
        exp_t e;
        if (rst) begin
            exp_q.delete();
            n_checks++;
            if (txd !== 1'b1 || owner !== 2'b00 || drops !== 8'd0) begin
                n_errors++;
                $display("FAIL reset_values: txd=%b owner=%b drops=%0d, want txd=1 owner=00 drops=0",
                         txd, owner, drops);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (txd !== e.txd || owner !== e.owner || drops !== e.drops) begin
                n_errors++;
                $display("FAIL output_cyc%0d: txd=%b owner=%b drops=%0d, want txd=%b owner=%b drops=%0d",
                         mon_cyc, txd, owner, drops, e.txd, e.owner, e.drops);
            end
        end
        mon_cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all return at posedge + 2)
    // ------------------------------------------------------------------
    task automatic wait_cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int src, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (src == 0) dbg_pin = fr[i];
            else          uart_pin = fr[i];
            wait_cyc(BIT_CYC);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        @(posedge clk);
        #2;
        wait_cyc(3);
        rst = 1'b0;

        // 1: idle line
        wait_cyc(1000);
        check("t1_txd", int'(txd), 1);
        check("t1_owner", int'(owner), 0);
        check("t1_drops", int'(drops), 0);

        // 2: dbg alone, release timing relative to the stop bit
        send(0, 8'h55);
        wait_cyc(273);
        check("t2_owner_held", int'(owner), 1);
        wait_cyc(5);
        check("t2_owner_released", int'(owner), 0);
        wait_cyc(100);

        // 3: simultaneous starts
        fork
            send(0, 8'hA5);
            send(1, 8'hA5);
        join
        wait_cyc(400);
        check("t3_drops", int'(drops), 1);
        check("t3_owner", int'(owner), 0);

        // 4: dbg mid-frame when the uart grant is released
        send(1, 8'h00);
        wait_cyc(175);
        fork
            send(0, 8'h0F);
            begin
                wait_cyc(150);
                check("t4_no_grant_mid", int'(owner), 0);
                check("t4_txd_idle", int'(txd), 1);
            end
        join
        fork
            send(0, 8'hA5);
            begin
                wait_cyc(30);
                check("t4_next_frame_grant", int'(owner), 1);
            end
        join
        wait_cyc(400);
        check("t4_drops", int'(drops), 2);

        // random contention
        for (int r = 0; r < 10; r++) begin
            int d1;
            int d2;
            d1 = int'($urandom_range(0, 300));
            d2 = ($urandom_range(0, 3) == 0) ? d1 : int'($urandom_range(0, 300));
            fork
                begin wait_cyc(d1); send(0, 8'($urandom)); end
                begin wait_cyc(d2); send(1, 8'($urandom)); end
            join
        end
        wait_cyc(400);

        // 5: saturation of the drop counter
        fork
            repeat (258) send(1, 8'h00);
            begin
                wait_cyc(10);
                repeat (256) send(0, 8'($urandom));
            end
        join
        wait_cyc(400);
        check("t5_drops_sat", int'(drops), 255);

        // 6: reset mid-frame
        fork
            send(0, 8'h00);
            begin
                wait_cyc(60);
                check("t6_txd_low", int'(txd), 0);
                rst = 1'b1;
                #1;
                check("t6_txd_async", int'(txd), 1);
                check("t6_owner_async", int'(owner), 0);
                check("t6_drops_async", int'(drops), 0);
            end
        join
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(20);
        fork
            send(0, 8'h3C);
            begin
                wait_cyc(30);
                check("t6_regrant", int'(owner), 1);
            end
        join
        wait_cyc(400);
        check("t6_owner_end", int'(owner), 0);
        check("t6_drops_end", int'(drops), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
